// File: rtl/cpu_pkg.sv
// Shared core definitions: datapath widths, HALT encoding and fetch states.
// Imported by fetch, decode and execute stages.
package cpu_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned INSTR_W = 17;

    localparam logic [ADDR_W-1:0]  RESET_PC   = 8'h00;
    localparam logic [INSTR_W-1:0] HALT_INSTR = 17'h1FFFF;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALTED
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, captures program-memory data into ir,
// hands it to decode over valid/ready, honours redirects and stops on HALT.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
    parameter int unsigned INSTR_W = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter logic [INSTR_W-1:0] HALT_INSTR = cpu_pkg::HALT_INSTR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [ADDR_W-1:0]  pc_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               halted
);

    fetch_state_t       state, state_d;
    logic [ADDR_W-1:0]  pc, pc_d;
    logic [INSTR_W-1:0] ir_d;
    logic [ADDR_W-1:0]  ir_pc_d;
    logic               valid_d;
    logic               take;

    assign take    = !ir_valid || ir_ready;
    assign pc_addr = pc;
    assign halted  = (state == HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            ir       <= ir_d;
            ir_pc    <= ir_pc_d;
            ir_valid <= valid_d;
        end
    end

    always_comb begin
        state_d = state;
        pc_d    = pc;
        ir_d    = ir;
        ir_pc_d = ir_pc;
        valid_d = ir_valid;
        unique case (state)
            IDLE: begin
                if (redirect) pc_d = redirect_pc;
                if (start) state_d = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    pc_d    = redirect_pc;
                end else if (take) begin
                    ir_d    = imem_data;
                    ir_pc_d = pc;
                    valid_d = 1'b1;
                    // HALT freezes the PC on its own address
                    if (imem_data == HALT_INSTR) state_d = HALTED;
                    else pc_d = pc + 1'b1;
                end
            end
            HALTED: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    pc_d    = redirect_pc;
                    state_d = FETCH;
                end else if (ir_valid && ir_ready) begin
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural fetch model checked every
// cycle plus literal expectations at key points.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  pc_addr;
    logic [16:0] imem_data;
    logic [16:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        halted;
    logic        halt_en;

    int compared = 0;
    int mismatched = 0;
    int acc10 = 0;

    always #5 clk = ~clk;

    function automatic logic [16:0] mem(input logic [7:0] a);
        if (halt_en && a == 8'h03) return 17'h1FFFF;
        return {9'b0, a};
    endfunction

    assign imem_data = mem(pc_addr);

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .pc_addr(pc_addr), .imem_data(imem_data),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid),
        .ir_ready(ir_ready), .redirect(redirect),
        .redirect_pc(redirect_pc), .halted(halted)
    );

    // Model: running flag, halted flag, PC and the presented slot
    logic        m_run, m_halt, m_valid;
    logic [7:0]  m_pc, m_irpc;
    logic [16:0] m_ir;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run <= 0; m_halt <= 0; m_valid <= 0;
            m_pc <= 8'h00; m_irpc <= 8'h00; m_ir <= '0;
        end else if (!m_run && !m_halt) begin
            if (redirect) m_pc <= redirect_pc;
            if (start) m_run <= 1;
        end else if (redirect) begin
            m_valid <= 0; m_pc <= redirect_pc;
            m_halt <= 0; m_run <= 1;
        end else if (m_halt) begin
            if (ir_ready) m_valid <= 0;
        end else if (!m_valid || ir_ready) begin
            m_ir <= mem(m_pc);
            m_irpc <= m_pc;
            m_valid <= 1;
            if (mem(m_pc) == 17'h1FFFF) begin
                m_halt <= 1; m_run <= 0;
            end else begin
                m_pc <= m_pc + 8'd1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc pc_addr", 32'(pc_addr), 32'(m_pc));
            chk("cyc ir_valid", 32'(ir_valid), 32'(m_valid));
            chk("cyc halted", 32'(halted), 32'(m_halt));
            if (m_valid) begin
                chk("cyc ir", 32'(ir), 32'(m_ir));
                chk("cyc ir_pc", 32'(ir_pc), 32'(m_irpc));
            end
            if (ir_valid && ir_ready && !redirect && ir_pc == 8'h10)
                acc10++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; start = 0; ir_ready = 1;
        redirect = 0; redirect_pc = 8'h00; halt_en = 0;
        #12;
        chk("rst pc_addr", 32'(pc_addr), 32'h00);
        chk("rst ir_valid", 32'(ir_valid), 32'h0);
        chk("rst halted", 32'(halted), 32'h0);
        chk("rst ir", 32'(ir), 32'h0);
        rst_n = 1;
        tick;
        start = 1;
        tick;
        start = 0;
        chk("start ir_valid", 32'(ir_valid), 32'h0);
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("seq ir", 32'(ir), i);
            chk("seq ir_pc", 32'(ir_pc), i);
            chk("seq ir_valid", 32'(ir_valid), 32'h1);
        end
        ir_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("stall ir", 32'(ir), 32'h5);
            chk("stall ir_pc", 32'(ir_pc), 32'h05);
            chk("stall pc_addr", 32'(pc_addr), 32'h06);
        end
        ir_ready = 1;
        tick;
        chk("unstall ir", 32'(ir), 32'h6);
        repeat (10) tick;
        chk("pre redir ir", 32'(ir), 32'h10);
        acc10 = 0;
        redirect = 1; redirect_pc = 8'h40;
        tick;
        redirect = 0;
        chk("redir ir_valid", 32'(ir_valid), 32'h0);
        chk("redir pc_addr", 32'(pc_addr), 32'h40);
        tick;
        chk("redir ir", 32'(ir), 32'h40);
        chk("redir ir_pc", 32'(ir_pc), 32'h40);
        chk("squash not accepted", 32'(acc10), 32'h0);
        redirect = 1; redirect_pc = 8'hFE;
        tick;
        redirect = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("wrap ir_pc", 32'(ir_pc), 32'((8'hFE + i) % 256));
        end
        halt_en = 1;
        redirect = 1; redirect_pc = 8'h00;
        tick;
        redirect = 0;
        repeat (3) tick;
        chk("pre halt ir_pc", 32'(ir_pc), 32'h02);
        tick;
        chk("halt ir", 32'(ir), 32'h1FFFF);
        chk("halt ir_pc", 32'(ir_pc), 32'h03);
        chk("halt halted", 32'(halted), 32'h1);
        chk("halt pc_addr", 32'(pc_addr), 32'h03);
        ir_ready = 0;
        tick;
        chk("halt held valid", 32'(ir_valid), 32'h1);
        chk("halt held ir", 32'(ir), 32'h1FFFF);
        ir_ready = 1;
        tick;
        chk("halt acc valid", 32'(ir_valid), 32'h0);
        chk("halt acc pc", 32'(pc_addr), 32'h03);
        tick;
        chk("halt stay", 32'(halted), 32'h1);
        redirect = 1; redirect_pc = 8'h00;
        tick;
        redirect = 0;
        chk("unhalt halted", 32'(halted), 32'h0);
        chk("unhalt pc", 32'(pc_addr), 32'h00);
        tick;
        chk("resume ir_pc", 32'(ir_pc), 32'h00);
        chk("resume valid", 32'(ir_valid), 32'h1);
        halt_en = 0;
        redirect = 1; redirect_pc = 8'h20;
        tick;
        redirect = 0;
        repeat (2) tick;
        chk("pre rst pc", 32'(pc_addr), 32'h22);
        chk("pre rst valid", 32'(ir_valid), 32'h1);
        #2 rst_n = 0;
        #1;
        chk("arst valid", 32'(ir_valid), 32'h0);
        chk("arst pc", 32'(pc_addr), 32'h00);
        chk("arst halted", 32'(halted), 32'h0);
        #1 rst_n = 1;
        repeat (2) tick;
        chk("idle valid", 32'(ir_valid), 32'h0);
        chk("idle pc", 32'(pc_addr), 32'h00);
        redirect = 1; redirect_pc = 8'h10;
        tick;
        redirect = 0;
        tick;
        chk("idle redir pc", 32'(pc_addr), 32'h10);
        chk("idle redir valid", 32'(ir_valid), 32'h0);
        start = 1; redirect = 1; redirect_pc = 8'h30;
        tick;
        start = 0; redirect = 0;
        chk("st+rd pc", 32'(pc_addr), 32'h30);
        tick;
        chk("st+rd ir_pc", 32'(ir_pc), 32'h30);
        chk("st+rd valid", 32'(ir_valid), 32'h1);
        tick;
        chk("st+rd next", 32'(ir_pc), 32'h31);
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the combinational program memory.
- Owns the program counter, drives the 8-bit program-memory address, and captures the returned 17-bit instruction into an instruction register.
- Presents the instruction to decode through a valid/ready handshake.
- Accepts redirect (branch/jump) requests from execute and stops fetching on a HALT instruction.

Parameters:
- ADDR_W, 8, program-memory address width and PC width.
- INSTR_W, 17, instruction width.
- RESET_PC, 8'h00, PC value loaded at reset.
- HALT_INSTR, 17'h1FFFF, encoding that stops fetch.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  leave IDLE and begin fetching at the current PC.
- pc_addr  output  ADDR_W  address to program memory; equals the PC register.
- imem_data  input  INSTR_W  instruction returned combinationally for pc_addr in the same cycle.
- ir  output  INSTR_W  instruction register.
- ir_pc  output  ADDR_W  address from which ir was fetched.
- ir_valid  output  1  ir holds an instruction for decode.
- ir_ready  input  1  decode accepts ir this cycle.
- redirect  input  1  execute requests PC change (squash).
- redirect_pc  input  ADDR_W  new PC when redirect=1.
- halted  output  1  fetch stopped on HALT.

Behaviour:
- Reset (async assert, deassert synchronous to clk is the integrator's job):
  - pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, halted=0, state=IDLE.
  - Reset mid-operation discards any in-flight instruction.
- States:
  - IDLE: no capture, pc holds.
    - start=1 -> FETCH.
    - redirect=1 in IDLE loads pc=redirect_pc and stays in IDLE.
  - FETCH: define take = !ir_valid || ir_ready.
    - take=1:
      - ir<=imem_data, ir_pc<=pc, ir_valid<=1.
      - pc<=pc+1, modulo 2^ADDR_W (8'hFF wraps to 8'h00).
    - take=0 (ir_valid && !ir_ready): ir, ir_pc, ir_valid and pc all hold (back-pressure stall).
    - Captured imem_data==HALT_INSTR:
      - HALT is presented (ir_valid=1).
      - pc does NOT advance.
      - Next state HALTED; halted=1 from the next cycle.
  - HALTED:
    - No capture and pc frozen.
    - ir_valid drops to 0 after the HALT is accepted (ir_ready=1).
    - Otherwise the HALT stays presented.
    - Only redirect or reset leaves HALTED.
- Redirect:
  - Highest priority in FETCH and HALTED.
  - Same cycle: ir_valid<=0, pc<=redirect_pc, halted<=0, state<=FETCH.
  - No capture that cycle, even if take=1.
  - First instruction from redirect_pc appears in ir one cycle later (2 edges after redirect assertion).
- Latency:
  - pc_addr to ir is 1 cycle.
  - Sustained throughput is 1 instruction/cycle when ir_ready=1.
- Simultaneous start and redirect in IDLE: redirect loads pc; start is honoured, so next state is FETCH.
- Handshake rule: once ir_valid=1, ir and ir_pc must stay stable until ir_ready=1 or redirect.
- halted is a registered output and equals (state==HALTED).
- Outputs are registered except pc_addr, which is the pc register itself (no combinational path from inputs to pc_addr).

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W and INSTR_W constants.
  - HALT_INSTR encoding.
  - fetch_state_t enum {IDLE, FETCH, HALTED}.
  - Decode and execute stages import the same package.
- No sub-module is required. The PC incrementer and instruction register are simple enough to stay in fetch_unit.
- The bench instantiates fetch_unit with the program-memory model.

Test Plan:
- Bench memory model returns imem_data={9'b0,pc_addr}.
- Reset release, start=1 at cycle 0, ir_ready=1:
  - Expected (ir,ir_pc) sequence (0x00000,0x00),(0x00001,0x01),(0x00002,0x02).
  - One per cycle; ir_valid rises 1 cycle after start.
- Back-pressure: ir_ready=0 for 3 cycles while ir=0x00005:
  - ir, ir_pc=0x05 and pc_addr=0x06 hold all 3 cycles.
  - ir_ready=1 -> next ir=0x00006.
- Redirect: redirect=1, redirect_pc=0x40, while ir=0x00010 valid:
  - Next cycle ir_valid=0, pc_addr=0x40.
  - Following cycle ir=0x00040, ir_pc=0x40.
  - 0x00010 is never accepted.
- Wrap: redirect_pc=0xFE, ir_ready=1:
  - ir_pc sequence 0xFE, 0xFF, 0x00, 0x01.
- HALT: memory returns 17'h1FFFF at 0x03:
  - ir=0x1FFFF, ir_pc=0x03; halted=1 next cycle.
  - pc_addr stays 0x03; ir_valid=0 after acceptance.
  - Then redirect_pc=0x00 clears halted and fetch resumes at 0x00.
- Async reset mid-stream: assert rst_n=0 between edges while ir_valid=1, pc=0x22:
  - Immediately ir_valid=0, pc_addr=0x00, halted=0.
  - State IDLE until start.
